mtm_alu_serializer: RTL
=======================

MTM_ALU_SERIALIZER -- requirements
Module: mtm_alu_serializer

Interface
REQ-001 SHALL have parameter BIT_CYCLES, default 1, clock cycles per serial bit (legal range 1..255).
REQ-002 SHALL have parameter IFG_BITS, default 0, idle-high bit periods between consecutive frames of one command (legal range 0..15).
REQ-003 SHALL have port clk  in  1  single clock; all logic on posedge.
REQ-004 SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have port start  in  1  command request; honoured only while busy=0.
REQ-006 SHALL have port a  in  32  operand A.
REQ-007 SHALL have port b  in  32  operand B.
REQ-008 SHALL have port op  in  3  operation code, sent unmodified (illegal codes allowed).
REQ-009 SHALL have port data_len  in  4  number of data frames to send, 0..15; 8 is a well-formed command.
REQ-010 SHALL have port crc_bad  in  1  when 1, the CTL frame carries CRC with bit 0 inverted.
REQ-011 SHALL have port sin  out  1  serial line to the ALU; idle level 1.
REQ-012 SHALL have port busy  out  1  command in progress.
REQ-013 SHALL have port done  out  1  one-cycle pulse at command completion.

Function
REQ-014 SHALL, on the clk edge where start=1 and busy=0, capture a, b, op, data_len and crc_bad into internal registers; from the next cycle busy=1 and sin carries the first start bit.
REQ-015 SHALL ignore start while busy=1; captured values SHALL NOT change mid-command.
REQ-016 SHALL send every frame as 11 bits, MSB first: start 0, type bit (0 data, 1 CTL), 8 payload bits d7..d0, stop 1.
REQ-017 SHALL hold each bit on sin for exactly BIT_CYCLES clocks.
REQ-018 SHALL send data frame k (k=0..data_len-1) with payload byte k of the sequence b[31:24], b[23:16], b[15:8], b[7:0], a[31:24], a[23:16], a[15:8], a[7:0]; for k>=8 the payload SHALL be 8'h00.
REQ-019 SHALL always follow the data frames with one CTL frame with payload {1'b0, op, crc4}; with data_len=0 only the CTL frame is sent.
REQ-020 SHALL compute crc4 as the remainder of M·x^4 mod (x^4+x+1), initial value 0, where M={b,a,1'b1,op} is 68 bits MSB first; crc4 is independent of data_len.
REQ-021 SHALL insert IFG_BITS idle bit periods (sin=1) between consecutive frames, and none after the CTL frame.
REQ-022 SHALL implement FSM states IDLE, START, TYPE, PAYLOAD, STOP, GAP: IDLE->START on accepted start; START->TYPE->PAYLOAD (8 bits)->STOP; STOP->GAP if frames remain and IFG_BITS>0; STOP->START if frames remain and IFG_BITS=0; GAP->START after IFG_BITS periods; STOP->IDLE after the CTL frame.
REQ-023 SHALL pulse done=1 for exactly one cycle on the cycle after the last CTL stop-bit period ends; busy SHALL drop to 0 in that same cycle.
REQ-024 SHALL accept a start asserted in the done cycle, so back-to-back commands have no extra idle.
REQ-025 SHALL take exactly (data_len+1)·11·BIT_CYCLES + data_len·IFG_BITS·BIT_CYCLES cycles from the first busy cycle to the last busy cycle.
REQ-026 SHALL compute the CRC combinationally or iteratively, and the CRC SHALL be valid before the CTL payload is transmitted, with no added latency.

Reset
REQ-027 SHALL, while reset_n=0, force sin=1, busy=0, done=0 and FSM=IDLE asynchronously, and clear all counters and captured registers.
REQ-028 SHALL, on reset assertion mid-frame, abandon the command immediately with no done pulse; after release the block SHALL sit in IDLE with sin=1.
REQ-029 SHALL accept start no earlier than the first clk edge after reset_n rises.

Verification
REQ-030 SHALL be tested with a=0, b=0, op=3'b000, data_len=8, BIT_CYCLES=1 -> 8 data frames 0 0 00000000 1, then CTL frame 0 1 00001011 1, then done pulse at busy-cycle 100; busy high for 99 cycles.
REQ-031 SHALL be tested with a=32'h01020304, b=32'hA0B0C0D0, data_len=8 -> data payloads A0,B0,C0,D0,01,02,03,04 in order.
REQ-032 SHALL be tested with data_len=7 and data_len=9 on the same operands -> 7 data frames, or 8 data frames plus a 00 frame; CTL CRC is identical in both cases.
REQ-033 SHALL be tested with a=0, b=0, op=0, crc_bad=1 -> CTL payload 8'h0A.
REQ-034 SHALL be tested with BIT_CYCLES=3, IFG_BITS=2, data_len=1 -> each bit lasts 3 cycles, 6 idle-high cycles between frames, and busy lasts 72 cycles.
REQ-035 SHALL be tested with reset_n pulsed low during payload bit 4 of frame 3 -> sin=1 and busy=0 immediately, no done pulse, and a new start afterwards completes normally.

Source files
------------

// File: rtl/mtm_alu_serializer_if.sv
// ---------------------------------------------------------------------------
// mtm_alu_serializer_if
// Command/serial bundle between a command source (master) and the
// mtm_alu_serializer (slave).
//   start     : command request, honoured only while busy is low
//   a, b      : 32-bit operands
//   op        : 3-bit operation code, forwarded unmodified
//   data_len  : number of data frames to send (0..15)
//   crc_bad   : invert bit 0 of the CRC carried in the CTL frame
//   sin       : serial line to the ALU, idles high
//   busy      : command in progress
//   done      : one-cycle completion pulse
// ---------------------------------------------------------------------------
interface mtm_alu_serializer_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [3:0]  data_len;
    logic        crc_bad;
    logic        sin;
    logic        busy;
    logic        done;

    modport master (
        output start, a, b, op, data_len, crc_bad,
        input  sin, busy, done
    );

    modport slave (
        input  start, a, b, op, data_len, crc_bad,
        output sin, busy, done
    );
endinterface

// File: rtl/mtm_alu_serializer.sv
// ---------------------------------------------------------------------------
// mtm_alu_serializer
// Turns one ALU command into a stream of 11-bit serial frames on sin:
// data_len data frames carrying operand bytes (B first, then A, MSB byte
// first, zero bytes beyond the eighth), followed by one CTL frame carrying
// {0, op, crc4}. Each bit is held for BIT_CYCLES clocks and IFG_BITS idle
// bit periods separate consecutive frames.
// Ports:
//   clk     : clock, everything on the rising edge
//   reset_n : asynchronous active-low reset
//   bus     : slave side of mtm_alu_serializer_if (start/a/b/op/data_len/
//             crc_bad in, sin/busy/done out)
// ---------------------------------------------------------------------------
module mtm_alu_serializer #(
    parameter int BIT_CYCLES = 1,
    parameter int IFG_BITS   = 0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    mtm_alu_serializer_if.slave      bus
);

    localparam logic [7:0] BIT_LAST = 8'(BIT_CYCLES - 1);
    localparam logic [3:0] GAP_LAST = 4'(IFG_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_TYPE    = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_STOP    = 3'd4,
        ST_GAP     = 3'd5
    } state_t;

    // CRC-4 with generator x^4+x+1, zero seed: clocking the message through
    // this LFSR MSB first yields the remainder of msg*x^4.
    function automatic logic [3:0] crc4_f(input logic [67:0] msg);
        logic [3:0] rem;
        logic       fb;
        rem = 4'h0;
        for (int i = 67; i >= 0; i--) begin
            fb  = rem[3] ^ msg[i];
            rem = {rem[2:0], 1'b0} ^ (fb ? 4'h3 : 4'h0);
        end
        return rem;
    endfunction

    state_t      state_q;
    logic        sin_q;
    logic        busy_q;
    logic        done_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [2:0]  op_q;
    logic [3:0]  len_q;
    logic [3:0]  crc_q;
    logic [7:0]  bit_cnt_q;
    logic [3:0]  frame_q;
    logic [2:0]  pay_cnt_q;
    logic [3:0]  gap_cnt_q;
    logic [7:0]  shift_q;

    logic [3:0]  crc_d;
    logic [7:0]  byte_d;
    logic        bit_end_s;
    logic        last_frame_s;

    // CRC of the command being accepted, so it is ready long before the CTL frame.
    always_comb begin
        crc_d = crc4_f({bus.b, bus.a, 1'b1, bus.op}) ^ {3'b000, bus.crc_bad};
    end

    // Bit-period end strobe and "current frame is the CTL frame" flag.
    always_comb begin
        bit_end_s    = (bit_cnt_q == BIT_LAST);
        last_frame_s = (frame_q == len_q);
    end

    // Payload byte of the frame currently being sent.
    always_comb begin
        byte_d = 8'h00;
        if (last_frame_s) begin
            byte_d = {1'b0, op_q, crc_q};
        end else begin
            case (frame_q)
                4'd0:    byte_d = b_q[31:24];
                4'd1:    byte_d = b_q[23:16];
                4'd2:    byte_d = b_q[15:8];
                4'd3:    byte_d = b_q[7:0];
                4'd4:    byte_d = a_q[31:24];
                4'd5:    byte_d = a_q[23:16];
                4'd6:    byte_d = a_q[15:8];
                4'd7:    byte_d = a_q[7:0];
                default: byte_d = 8'h00;
            endcase
        end
    end

    // Frame sequencer; sin_q always carries the level of the state being entered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            sin_q     <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            a_q       <= 32'h0000_0000;
            b_q       <= 32'h0000_0000;
            op_q      <= 3'b000;
            len_q     <= 4'h0;
            crc_q     <= 4'h0;
            bit_cnt_q <= 8'h00;
            frame_q   <= 4'h0;
            pay_cnt_q <= 3'd0;
            gap_cnt_q <= 4'h0;
            shift_q   <= 8'h00;
        end else begin
            done_q <= 1'b0;
            if (state_q == ST_IDLE) begin
                bit_cnt_q <= 8'h00;
            end else if (bit_end_s) begin
                bit_cnt_q <= 8'h00;
            end else begin
                bit_cnt_q <= bit_cnt_q + 8'd1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        op_q    <= bus.op;
                        len_q   <= bus.data_len;
                        crc_q   <= crc_d;
                        frame_q <= 4'h0;
                        busy_q  <= 1'b1;
                        sin_q   <= 1'b0;
                        state_q <= ST_START;
                    end else begin
                        busy_q  <= 1'b0;
                        sin_q   <= 1'b1;
                    end
                end
                ST_START: begin
                    if (bit_end_s) begin
                        sin_q   <= last_frame_s;
                        state_q <= ST_TYPE;
                    end else begin
                        state_q <= ST_START;
                    end
                end
                ST_TYPE: begin
                    if (bit_end_s) begin
                        shift_q   <= byte_d;
                        sin_q     <= byte_d[7];
                        pay_cnt_q <= 3'd0;
                        state_q   <= ST_PAYLOAD;
                    end else begin
                        state_q   <= ST_TYPE;
                    end
                end
                ST_PAYLOAD: begin
                    if (bit_end_s) begin
                        if (pay_cnt_q == 3'd7) begin
                            sin_q   <= 1'b1;
                            state_q <= ST_STOP;
                        end else begin
                            pay_cnt_q <= pay_cnt_q + 3'd1;
                            shift_q   <= {shift_q[6:0], 1'b0};
                            sin_q     <= shift_q[6];
                        end
                    end else begin
                        state_q <= ST_PAYLOAD;
                    end
                end
                ST_STOP: begin
                    if (bit_end_s) begin
                        if (last_frame_s) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            sin_q   <= 1'b1;
                            state_q <= ST_IDLE;
                        end else if (IFG_BITS > 0) begin
                            frame_q   <= frame_q + 4'd1;
                            gap_cnt_q <= 4'h0;
                            sin_q     <= 1'b1;
                            state_q   <= ST_GAP;
                        end else begin
                            frame_q <= frame_q + 4'd1;
                            sin_q   <= 1'b0;
                            state_q <= ST_START;
                        end
                    end else begin
                        state_q <= ST_STOP;
                    end
                end
                ST_GAP: begin
                    if (bit_end_s) begin
                        if (gap_cnt_q == GAP_LAST) begin
                            sin_q   <= 1'b0;
                            state_q <= ST_START;
                        end else begin
                            gap_cnt_q <= gap_cnt_q + 4'd1;
                        end
                    end else begin
                        state_q <= ST_GAP;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    sin_q   <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.sin  = sin_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule
